// File: rtl/onfi_bus_cycle.sv
// ============================================================================
// Module   : onfi_bus_cycle
// Brief    : ONFI NAND bus-cycle engine (CMD/ADDR/WRITE/READ/WAIT_RDY).
// Revision : 1.0
// ============================================================================
`default_nettype none

module onfi_bus_cycle #(
    parameter int          T_WP     = 3,
    parameter int          T_WH     = 2,
    parameter int          T_RP     = 3,
    parameter int          T_REH    = 2,
    parameter int          T_WB     = 5,
    parameter logic [15:0] T_RDY_TO = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_byte,
    input  logic       ce_hold,
    input  logic       wp_n_i,
    output logic       done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       ALE,
    output logic       CLE,
    output logic       CE_n,
    output logic       WE_n,
    output logic       RE_n,
    output logic       WP_n,
    inout  wire  [7:0] DATA,
    input  logic       Ready
);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_SETUP = 4'd1;
    localparam logic [3:0] c_WLOW  = 4'd2;
    localparam logic [3:0] c_WHIGH = 4'd3;
    localparam logic [3:0] c_RLOW  = 4'd4;
    localparam logic [3:0] c_RHIGH = 4'd5;
    localparam logic [3:0] c_WB    = 4'd6;
    localparam logic [3:0] c_WRDY  = 4'd7;
    localparam logic [3:0] c_DONE  = 4'd8;

    localparam logic [2:0] c_OP_CMD   = 3'd0;
    localparam logic [2:0] c_OP_ADDR  = 3'd1;
    localparam logic [2:0] c_OP_WRITE = 3'd2;
    localparam logic [2:0] c_OP_READ  = 3'd3;
    localparam logic [2:0] c_OP_WAIT  = 3'd4;

    localparam logic [15:0] c_WP_LD  = 16'(T_WP - 1);
    localparam logic [15:0] c_WH_LD  = 16'(T_WH - 1);
    localparam logic [15:0] c_RP_LD  = 16'(T_RP - 1);
    localparam logic [15:0] c_REH_LD = 16'(T_REH - 1);
    localparam logic [15:0] c_WB_LD  = 16'(T_WB - 1);
    localparam logic [15:0] c_TO_LD  = T_RDY_TO - 16'd1;

    logic [3:0]  r_state, w_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic [2:0]  r_op, w_op;
    logic [7:0]  r_dout, r_rd_data;
    logic        r_done, r_err, r_cle, r_ale, r_oe, r_ce_n, r_we_n, r_re_n, r_wp_n;
    logic        r_rdy_meta, r_rdy_s;
    logic        w_accept, w_illegal, w_timeout, w_cnt_zero, w_drv_ph, w_wr_op, w_ce_low;

    assign w_accept   = cmd_valid && (r_state == c_IDLE);
    assign w_op       = w_accept ? cmd_op : r_op;
    assign w_illegal  = (w_op > c_OP_WAIT);
    assign w_wr_op    = (w_op <= c_OP_WRITE);
    assign w_cnt_zero = (r_cnt == 16'd0);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_timeout  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (cmd_op <= c_OP_READ) begin
                        w_next = c_SETUP;
                    end else if (cmd_op == c_OP_WAIT) begin
                        w_next     = c_WB;
                        w_cnt_next = c_WB_LD;
                    end else begin
                        w_next = c_DONE;
                    end
                end
            end
            c_SETUP: begin
                if (r_op == c_OP_READ) begin
                    w_next     = c_RLOW;
                    w_cnt_next = c_RP_LD;
                end else begin
                    w_next     = c_WLOW;
                    w_cnt_next = c_WP_LD;
                end
            end
            c_WLOW: begin
                if (w_cnt_zero) begin
                    w_next     = c_WHIGH;
                    w_cnt_next = c_WH_LD;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            c_WHIGH: begin
                if (w_cnt_zero) w_next = c_DONE;
                else            w_cnt_next = r_cnt - 16'd1;
            end
            c_RLOW: begin
                if (w_cnt_zero) begin
                    w_next     = c_RHIGH;
                    w_cnt_next = c_REH_LD;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            c_RHIGH: begin
                if (w_cnt_zero) w_next = c_DONE;
                else            w_cnt_next = r_cnt - 16'd1;
            end
            c_WB: begin
                if (w_cnt_zero) begin
                    w_next     = c_WRDY;
                    w_cnt_next = c_TO_LD;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            c_WRDY: begin
                // A Ready seen on the last budgeted cycle still counts as success
                if (r_rdy_s) begin
                    w_next = c_DONE;
                end else if (w_cnt_zero) begin
                    w_next    = c_DONE;
                    w_timeout = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Pins are computed from the next state so they change together with it
    assign w_drv_ph = (w_next == c_SETUP) || (w_next == c_WLOW) || (w_next == c_WHIGH);
    assign w_ce_low = ((w_next == c_IDLE) || ((w_next == c_DONE) && w_illegal)) ? ce_hold : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= 16'd0;
            r_op       <= c_OP_CMD;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cle      <= 1'b0;
            r_ale      <= 1'b0;
            r_oe       <= 1'b0;
            r_ce_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_re_n     <= 1'b1;
            r_wp_n     <= 1'b0;
            r_rdy_meta <= 1'b0;
            r_rdy_s    <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            if (w_accept) r_op <= cmd_op;
            r_done     <= (w_next == c_DONE);
            r_err      <= (w_next == c_DONE) && (w_illegal || w_timeout);
            r_cle      <= w_drv_ph && (w_op == c_OP_CMD);
            r_ale      <= w_drv_ph && (w_op == c_OP_ADDR);
            r_oe       <= w_drv_ph && w_wr_op;
            r_ce_n     <= !w_ce_low;
            r_we_n     <= !(w_next == c_WLOW);
            r_re_n     <= !(w_next == c_RLOW);
            r_wp_n     <= wp_n_i;
            r_rdy_meta <= Ready;
            r_rdy_s    <= r_rdy_meta;
            if ((r_state == c_RLOW) && w_cnt_zero) r_rd_data <= DATA;
        end
    end

    // Output byte is pure datapath; the output enable alone gates the pins
    always_ff @(posedge clk) begin
        if (w_accept) r_dout <= cmd_byte;
    end

    assign DATA      = r_oe ? r_dout : 8'hzz;
    assign cmd_ready = (r_state == c_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign rd_data   = r_rd_data;
    assign CLE       = r_cle;
    assign ALE       = r_ale;
    assign CE_n      = r_ce_n;
    assign WE_n      = r_we_n;
    assign RE_n      = r_re_n;
    assign WP_n      = r_wp_n;

endmodule

`default_nettype wire

// File: tb/tb_onfi_bus_cycle.sv
// ============================================================================
// Module   : tb_onfi_bus_cycle
// Brief    : Directed vector bench for onfi_bus_cycle with a NAND data model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_onfi_bus_cycle;

    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, ce_hold, wp_n_i, Ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_byte;
    logic       cmd_ready, done, err, ALE, CLE, CE_n, WE_n, RE_n, WP_n;
    logic [7:0] rd_data;
    wire  [7:0] DATA;
    logic       tb_drv;
    logic [7:0] tb_rd_byte;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Device model: returns tb_rd_byte while RE_n is low, else a zero probe
    assign DATA = tb_drv ? (RE_n ? 8'h00 : tb_rd_byte) : 8'hzz;

    onfi_bus_cycle dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_byte(cmd_byte), .ce_hold(ce_hold), .wp_n_i(wp_n_i),
        .done(done), .err(err), .rd_data(rd_data), .ALE(ALE), .CLE(CLE),
        .CE_n(CE_n), .WE_n(WE_n), .RE_n(RE_n), .WP_n(WP_n), .DATA(DATA), .Ready(Ready)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] byt;
        int         lat;
        int         err;
        int         cle_n;
        int         ale_n;
        int         we_n;
        int         we_first;
        int         re_n;
        int         re_first;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v);
        int cle_c = 0, ale_c = 0, we_c = 0, we_f = 0, we_l = 0;
        int re_c = 0, re_f = 0, ce_c = 0, rdy_busy = 0, data_bad = 0, done_at = 0;
        int err_seen = 0;
        logic [7:0] rd_seen = 8'h00;
        @(negedge clk);
        chk("ready_idle", cmd_ready, 1);
        chk("ce_idle", CE_n, 1);
        tb_drv    = (v.op > 3'd2);
        cmd_op    = v.op;
        cmd_byte  = v.byt;
        cmd_valid = 1'b1;
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            @(negedge clk);
            if (i == 1) cmd_valid = 1'b0;
            cle_c += int'(CLE);
            ale_c += int'(ALE);
            if (!WE_n) begin we_c++; if (we_f == 0) we_f = i; we_l = i; end
            if (!RE_n) begin re_c++; if (re_f == 0) re_f = i; end
            if (!CE_n) ce_c++;
            if (cmd_ready) rdy_busy++;
            if (v.op <= 3'd2 && !done && DATA !== v.byt) data_bad++;
            if (v.op > 3'd2 && DATA !== (RE_n ? 8'h00 : tb_rd_byte)) data_bad++;
            if (done) begin done_at = i; err_seen = int'(err); rd_seen = rd_data; end
        end
        tb_drv = 1'b0;
        chk("done_latency", done_at, v.lat);
        chk("err_flag", err_seen, v.err);
        chk("cle_cycles", cle_c, v.cle_n);
        chk("ale_cycles", ale_c, v.ale_n);
        chk("we_low_cycles", we_c, v.we_n);
        chk("we_first", we_f, v.we_first);
        chk("we_last", we_l, (v.we_n > 0) ? v.we_first + v.we_n - 1 : 0);
        chk("re_low_cycles", re_c, v.re_n);
        chk("re_first", re_f, v.re_first);
        chk("ce_low_cycles", ce_c, (v.err == 0) ? v.lat : 0);
        chk("ready_while_busy", rdy_busy, 0);
        chk("data_bus_bad", data_bad, 0);
        chk8("rd_data_at_done", rd_seen, v.rd);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d1, d2, nd, e, lows;

        //            op    byte   lat err cle ale we wf re rf rd
        vecs[0] = '{3'd0, 8'hFF, 7, 0, 6, 0, 3, 2, 0, 0, 8'h00};
        vecs[1] = '{3'd1, 8'h00, 7, 0, 0, 6, 3, 2, 0, 0, 8'h00};
        vecs[2] = '{3'd2, 8'hA5, 7, 0, 0, 0, 3, 2, 0, 0, 8'h00};
        vecs[3] = '{3'd3, 8'h77, 7, 0, 0, 0, 0, 0, 3, 2, 8'h3C};
        vecs[4] = '{3'd0, 8'h30, 7, 0, 6, 0, 3, 2, 0, 0, 8'h3C};
        vecs[5] = '{3'd6, 8'h11, 1, 1, 0, 0, 0, 0, 0, 0, 8'h3C};
        vecs[6] = '{3'd5, 8'h22, 1, 1, 0, 0, 0, 0, 0, 0, 8'h3C};
        vecs[7] = '{3'd2, 8'h5A, 7, 0, 0, 0, 3, 2, 0, 0, 8'h3C};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_byte = 8'h00;
        ce_hold = 1'b0; wp_n_i = 1'b1; Ready = 1'b0;
        tb_drv = 1'b1; tb_rd_byte = 8'h3C;
        repeat (3) @(negedge clk);
        chk("rst_ce_n", CE_n, 1);
        chk("rst_cle", CLE, 0);
        chk("rst_ale", ALE, 0);
        chk("rst_we_n", WE_n, 1);
        chk("rst_re_n", RE_n, 1);
        chk("rst_wp_n", WP_n, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk8("rst_rd_data", rd_data, 8'h00);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk8("rst_data_z", DATA, 8'h00);
        rst_n = 1'b1; tb_drv = 1'b0;
        @(negedge clk);
        chk("wp_n_follow", WP_n, 1);

        for (int i = 0; i < 8; i++) run_req(vecs[i]);

        // CE_n held low in idle under ce_hold
        @(negedge clk); ce_hold = 1'b1;
        @(negedge clk); chk("ce_hold_low", CE_n, 0);
        ce_hold = 1'b0;
        @(negedge clk); chk("ce_hold_release", CE_n, 1);

        // cmd_valid held high: second accept only once idle again
        @(negedge clk);
        cmd_op = 3'd0; cmd_byte = 8'h70; cmd_valid = 1'b1;
        d1 = 0; d2 = 0; nd = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 9) cmd_valid = 1'b0;
            if (done) begin nd++; if (d1 == 0) d1 = i; else d2 = i; end
        end
        chk("held_valid_done_count", nd, 2);
        chk("held_valid_first_done", d1, 7);
        chk("held_valid_second_done", d2, 15);

        // WAIT_RDY: Ready rises in cycle 20, done three cycles later
        @(negedge clk);
        cmd_op = 3'd4; cmd_valid = 1'b1;
        d1 = 0; e = 0; lows = 0;
        for (int i = 1; i <= 40 && d1 == 0; i++) begin
            @(negedge clk);
            if (i == 1) cmd_valid = 1'b0;
            if (i == 20) Ready = 1'b1;
            if (!WE_n || !RE_n || CE_n) lows++;
            if (done) begin d1 = i; e = int'(err); end
        end
        chk("wait_rdy_done", d1, 23);
        chk("wait_rdy_err", e, 0);
        chk("wait_rdy_pins", lows, 0);
        Ready = 1'b0;
        repeat (3) @(negedge clk);

        // WAIT_RDY timeout: k + T_WB + T_RDY_TO + 1
        cmd_op = 3'd4; cmd_valid = 1'b1;
        d1 = 0; e = 0;
        for (int i = 1; i <= 1100 && d1 == 0; i++) begin
            @(negedge clk);
            if (i == 1) cmd_valid = 1'b0;
            if (done) begin d1 = i; e = int'(err); end
        end
        chk("timeout_done", d1, 1006);
        chk("timeout_err", e, 1);

        // Asynchronous reset during WLOW of a WRITE
        @(negedge clk);
        cmd_op = 3'd2; cmd_byte = 8'h5A; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_we_low_before_reset", WE_n, 0);
        #2; rst_n = 1'b0; tb_drv = 1'b1;
        #1;
        chk("mid_rst_we_n", WE_n, 1);
        chk("mid_rst_ce_n", CE_n, 1);
        chk8("mid_rst_data_z", DATA, 8'h00);
        nd = 0;
        repeat (3) begin @(negedge clk); nd += int'(done); end
        rst_n = 1'b1; tb_drv = 1'b0;
        repeat (10) begin @(negedge clk); nd += int'(done); end
        chk("mid_rst_no_done", nd, 0);
        run_req(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/onfi_bus_cycle.md
# onfi_bus_cycle

NAND bus-cycle engine sitting directly downstream of `onfi_ctrl` and driving the ONFI pins in place of the bare pin stub. It accepts one bus-cycle request at a time over a valid/ready handshake: command latch, address latch, data write, data read, or wait-for-ready. It turns each request into correctly timed CE_n/CLE/ALE/WE_n/RE_n/DATA activity using parameterised cycle counts. It reports completion with a one-cycle `done` pulse, plus read data or an error flag.

## Interface
- `T_WP`, 3: WE_n low width, cycles (≥1)
- `T_WH`, 2: WE_n high/hold width, cycles (≥1)
- `T_RP`, 3: RE_n low width, cycles (≥1)
- `T_REH`, 2: RE_n high/hold width, cycles (≥1)
- `T_WB`, 5: cycles ignored before sampling Ready (≥1)
- `T_RDY_TO`, 16'd1000: Ready timeout, cycles in WRDY (≥1, 16-bit)
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: request present
- `cmd_ready` out 1: engine idle, request accepted when `cmd_valid & cmd_ready`
- `cmd_op` in 3: 0 CMD, 1 ADDR, 2 WRITE, 3 READ, 4 WAIT_RDY, 5–7 illegal
- `cmd_byte` in 8: byte for CMD/ADDR/WRITE, ignored otherwise
- `ce_hold` in 1: keep CE_n low while idle (multi-cycle sequences)
- `wp_n_i` in 1: write-protect request, registered to `WP_n`
- `done` out 1: one-cycle completion pulse
- `err` out 1: valid with `done`; 1 = illegal op or Ready timeout
- `rd_data` out 8: byte captured by last READ, held until next READ
- `ALE`, `CLE` out 1; `CE_n`, `WE_n`, `RE_n`, `WP_n` out 1; `DATA` inout 8; `Ready` in 1 (async, R/B#)

## Operation
- States: IDLE, SETUP, WLOW, WHIGH, RLOW, RHIGH, WB, WRDY, DONE. `cmd_ready` = (state==IDLE), combinational.
- Accept in IDLE: latch op/byte, then:
  - CMD/ADDR/WRITE → SETUP.
  - READ → SETUP.
  - WAIT_RDY → WB.
  - Illegal op → DONE with err=1, no pin activity.
- SETUP (1 cycle): CE_n=0; CLE=1 for CMD, ALE=1 for ADDR. DATA driven with the byte for CMD/ADDR/WRITE, high-Z for READ. Next state is WLOW for writes, RLOW for READ.
- WLOW: WE_n=0 for T_WP cycles, then WHIGH. WHIGH: WE_n=1 for T_WH cycles, CLE/ALE/DATA held, then DONE.
- RLOW: RE_n=0 for T_RP cycles. DATA is sampled into `rd_data` on the rising edge ending the last RLOW cycle. Then RHIGH: RE_n=1 for T_REH cycles, then DONE.
- WB: CE_n=0, T_WB cycles, then WRDY.
- WRDY: wait for `rdy_s`, Ready through a 2-FF synchroniser. `rdy_s`=1 → DONE err=0. If T_RDY_TO cycles elapse in WRDY → DONE err=1.
- DONE: `done`=1 one cycle; CLE/ALE deasserted; DATA released; → IDLE.
- CE_n = 0 in every non-IDLE state, and in IDLE when `ce_hold`=1 (registered).
- All pin outputs are registered; one 16-bit down-counter is shared by all timed states.
- `cmd_valid` while busy is ignored, since `cmd_ready`=0.
- DATA output-enable is high only in SETUP/WLOW/WHIGH of CMD/ADDR/WRITE. It is never enabled in the same cycle as RE_n=0.

## Timing
- Cycle k = handshake cycle.
- CMD/ADDR/WRITE: SETUP k+1, WLOW k+2..k+1+T_WP, WHIGH next T_WH cycles, `done` at k+2+T_WP+T_WH. With defaults, `done` is at k+7.
- READ: RLOW k+2..k+4, capture at end of k+4, RHIGH k+5..k+6. `done` and new `rd_data` are visible at k+7 (defaults).
- WAIT_RDY: WB k+1..k+T_WB, WRDY from k+T_WB+1. `done` is the cycle after `rdy_s` is first seen high in WRDY. Pin-to-`rdy_s` latency is 2 cycles.
- Illegal op: `done`/`err` at k+1.
- Back-to-back: next accept no earlier than the cycle after DONE; `cmd_ready` returns high in that cycle.
- Reset values:
  - CE_n=1, CLE=0, ALE=0, WE_n=1, RE_n=1, WP_n=0.
  - DATA high-Z.
  - done=0, err=0, rd_data=8'h00.
  - State IDLE, so `cmd_ready`=1.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous); no `done` is issued for the aborted request.

## Test plan
- CMD 8'hFF at k (defaults) → CLE=1 and DATA=FF during k+1..k+6. WE_n low exactly k+2..k+4. `done`=1, err=0 only at k+7. CE_n=1 from k+8 with `ce_hold`=0.
- ADDR 8'h00 then WRITE 8'hA5 back-to-back → ALE only during the first cycle, DATA=A5 in the second. Second accept at the first cycle `cmd_ready`=1 after DONE. Each WE_n low pulse is 3 cycles.
- READ with model driving 8'h3C while RE_n low → DATA never driven by the DUT. `rd_data`=3C at `done` and held through a following CMD.
- WAIT_RDY with Ready low 20 cycles then high → `done` err=0 exactly 3 cycles after Ready rises. With Ready held low → `done` err=1 at k+T_WB+T_RDY_TO+1.
- `cmd_op`=6 → `done`/`err`=1 at k+1, no pin toggles. `cmd_valid` held during a CMD is not accepted until IDLE.
- Assert `rst_n`=0 during WLOW of a WRITE → WE_n=1, CE_n=1, DATA high-Z without waiting for a clock edge, no `done`. After release, a new CMD completes normally.
